// File: rtl/sub16_serial_pkg.sv
// sub16_serial_pkg: shared FSM encoding and default widths for the serial subtractor.
// Rev 1.0 - initial release.
`default_nettype none

package sub16_serial_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_SLICE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sub16_serial_if.sv
// sub16_serial_if: operand/result bundle between requester (master) and subtractor (slave).
// Rev 1.0 - initial release. ovf exists only when SUB16_OVF_EN is defined.
`default_nettype none

interface sub16_serial_if
   import sub16_serial_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);
   logic              start;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              b_in;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] diff;
   logic              b_out;
`ifdef SUB16_OVF_EN
   logic              ovf;
`endif

   modport master (
      output start, a, b, b_in,
`ifdef SUB16_OVF_EN
      input  ovf,
`endif
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, a, b, b_in,
`ifdef SUB16_OVF_EN
      output ovf,
`endif
      output busy, done, diff, b_out
   );

endinterface

`default_nettype wire

// File: rtl/sub16_serial_sub4.sv
// sub4: combinational W-bit ripple subtractor, d = x - y - bin, bout = final borrow.
// Rev 1.0 - initial release.
`default_nettype none

module sub4 #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_y,
   input  logic         i_bin,
   output logic [W-1:0] o_d,
   output logic         o_bout
);

   always_comb begin
      logic v_c;
      v_c = i_bin;
      o_d = '0;
      for (int i = 0; i < W; i++) begin
         o_d[i] = i_x[i] ^ i_y[i] ^ v_c;
         // Borrow out of a bit: x < y, or x == y with an incoming borrow.
         v_c = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & v_c);
      end
      o_bout = v_c;
   end

endmodule

`default_nettype wire

// File: rtl/sub16_serial.sv
// sub16_serial: multi-cycle subtractor, one SLICE_W slice per cycle, LSB first.
// Rev 1.0 - initial release. Define SUB16_OVF_EN to add the signed-overflow output.
`default_nettype none

module sub16_serial
   import sub16_serial_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SLICE_W = DEF_SLICE_W
) (
   input  logic          clk,
   input  logic          rst_n,
   sub16_serial_if.slave bus
);

   localparam int N     = DATA_W / SLICE_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);

   state_t             r_state;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic [DATA_W-1:0]  r_acc;
   logic               r_borrow;
   logic [IDX_W-1:0]   r_idx;
   logic               r_busy;
   logic               r_done;
   logic [DATA_W-1:0]  r_diff;
   logic               r_bout;
`ifdef SUB16_OVF_EN
   logic               r_amsb;
   logic               r_bmsb;
   logic               r_ovf;
`endif

   logic [SLICE_W-1:0] w_d;
   logic               w_bout;
   logic [DATA_W-1:0]  w_acc_next;

   sub4 #(.W(SLICE_W)) u_sub4 (
      .i_x    (r_a[SLICE_W-1:0]),
      .i_y    (r_b[SLICE_W-1:0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bout)
   );

   // Each new slice enters at the top, so after N cycles the accumulator is LSB-aligned.
   generate
      if (N == 1) begin : g_acc_single
         assign w_acc_next = w_d;
      end else begin : g_acc_multi
         assign w_acc_next = {w_d, r_acc[DATA_W-1:SLICE_W]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_borrow <= 1'b0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
`ifdef SUB16_OVF_EN
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b;
                  r_borrow <= bus.b_in;
                  r_acc    <= '0;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
`ifdef SUB16_OVF_EN
                  r_amsb   <= bus.a[DATA_W-1];
                  r_bmsb   <= bus.b[DATA_W-1];
`endif
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a      <= r_a >> SLICE_W;
               r_b      <= r_b >> SLICE_W;
               r_acc    <= w_acc_next;
               r_borrow <= w_bout;
               r_idx    <= r_idx + 1'b1;
               if (r_idx == c_LAST_IDX) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_diff  <= w_acc_next;
                  r_bout  <= w_bout;
`ifdef SUB16_OVF_EN
                  r_ovf   <= (r_amsb != r_bmsb) && (w_acc_next[DATA_W-1] != r_amsb);
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.diff  = r_diff;
   assign bus.b_out = r_bout;
`ifdef SUB16_OVF_EN
   assign bus.ovf   = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed and random checks of sub16_serial against an arithmetic model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_sub16_serial;
   import sub16_serial_pkg::*;

   localparam int DW = 16;
   localparam int SW = 4;
   localparam int N  = DW / SW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sub16_serial_if #(.DATA_W(DW)) bus ();

   sub16_serial #(.DATA_W(DW), .SLICE_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                                 output logic [15:0] d, output logic bo, output logic ov);
      int unsigned ua, ub;
      ua = a;
      ub = b + bi;
      d  = 16'(ua - ub);
      bo = (ua < ub);
      ov = (a[15] != b[15]) && (d[15] != a[15]);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input logic bi);
      logic [15:0] ed;
      logic eb, eo;
      model(a, b, bi, ed, eb, eo);
      check({tag, " diff"}, 32'(bus.diff), 32'(ed));
      check({tag, " b_out"}, 32'(bus.b_out), 32'(eb));
`ifdef SUB16_OVF_EN
      check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
`endif
      check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bi);
      int cyc;
      logic [15:0] held;
      bus.start = 1'b1; bus.a = a; bus.b = b; bus.b_in = bi;
      tick();
      bus.start = 1'b0;
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      wait_done(cyc);
      check({tag, " latency"}, 32'(cyc), 32'(N));
      check_result(tag, a, b, bi);
      held = bus.diff;
      tick();
      check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, " diff_hold"}, 32'(bus.diff), 32'(held));
   endtask

   initial begin
      int cyc, ndone;
      logic [15:0] ra, rb;
      logic rbi;

      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
      tick(); tick();
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset diff", 32'(bus.diff), 32'd0);
      check("reset b_out", 32'(bus.b_out), 32'd0);
`ifdef SUB16_OVF_EN
      check("reset ovf", 32'(bus.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      do_op("basic", 16'h1234, 16'h0234, 1'b0);
      do_op("wrap", 16'h0000, 16'h0001, 1'b0);
      do_op("eq_bin", 16'h0005, 16'h0005, 1'b1);
      do_op("max", 16'hFFFF, 16'hFFFF, 1'b0);
`ifdef SUB16_OVF_EN
      do_op("ovf_neg", 16'h8000, 16'h0001, 1'b0);
      do_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0);
      do_op("ovf_none", 16'h0003, 16'h0001, 1'b0);
`endif

      for (int i = 0; i < 20; i++) begin
         do_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
      end

      // start held through RUN with operands changing every cycle
      ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
      bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.b_in = rbi;
      tick();
      ndone = 0;
      for (int i = 0; i < N; i++) begin
         bus.a = 16'($urandom); bus.b = 16'($urandom); bus.b_in = 1'($urandom);
         tick();
         if (bus.done === 1'b1) ndone++;
      end
      bus.start = 1'b0;
      check("hold done_at_N", 32'(bus.done), 32'd1);
      check_result("hold", ra, rb, rbi);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done === 1'b1) ndone++;
      end
      check("hold done_count", 32'(ndone), 32'd1);

      // back-to-back: new start in the done cycle
      ra = 16'($urandom); rb = 16'($urandom);
      bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1111; bus.b_in = 1'b0;
      tick();
      bus.start = 1'b0;
      wait_done(cyc);
      check_result("b2b first", 16'h4321, 16'h1111, 1'b0);
      bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.b_in = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(cyc);
      check("b2b spacing", 32'(cyc + 1), 32'(N + 1));
      check_result("b2b second", ra, rb, 1'b1);
      tick();

      // reset during RUN
      bus.start = 1'b1; bus.a = 16'h9876; bus.b = 16'h0123; bus.b_in = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst diff", 32'(bus.diff), 32'd0);
      check("rst b_out", 32'(bus.b_out), 32'd0);
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done === 1'b1) ndone++;
      end
      check("rst no_done", 32'(ndone), 32'd0);
      do_op("after_rst", 16'hFFFF, 16'h0001, 1'b0);
      check("after_rst value", 32'(bus.diff), 32'h0000FFFE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sub16_serial.md
SUB16_SERIAL -- requirements
Module: sub16_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE_W, default 4, bits processed per cycle; DATA_W SHALL be an integer multiple of SLICE_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to subtract; sampled on the rising clk edge.
REQ-006 SHALL have port a  input  DATA_W  minuend; captured when start is accepted.
REQ-007 SHALL have port b  input  DATA_W  subtrahend; captured when start is accepted.
REQ-008 SHALL have port b_in  input  1  borrow-in; captured when start is accepted.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have port diff  output  DATA_W  result a - b - b_in modulo 2^DATA_W.
REQ-012 SHALL have port b_out  output  1  final borrow; 1 iff a < b + b_in, unsigned.
REQ-013 SHALL have port ovf  output  1  signed overflow, present only with SUB16_OVF_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL accept start only when busy = 0, i.e. in IDLE or DONE, and SHALL ignore start while busy = 1.
REQ-016 On acceptance, SHALL register a, b and b_in, clear the slice index, enter RUN and set busy.
REQ-017 In RUN, SHALL compute one SLICE_W slice per cycle, LSB slice first, chaining the borrow through a registered borrow bit seeded by b_in.
REQ-018 SHALL take N = DATA_W/SLICE_W RUN cycles (4 at defaults).
REQ-019 After the Nth slice, SHALL enter DONE, drop busy, pulse done for exactly one cycle and update diff/b_out (and ovf) in that same cycle.
REQ-020 Latency: for start sampled at edge k, done SHALL be high for the cycle following edge k+N.
REQ-021 SHALL hold diff/b_out (and ovf) stable from done until the edge after the next accepted start.
REQ-022 SHALL return from DONE to IDLE after one cycle, unless start is asserted, in which case it SHALL go directly to RUN (back-to-back, one result per N+1 cycles).
REQ-023 SHALL ignore operand changes during RUN.
REQ-024 Wrap-around: 0x0000 - 0x0001 SHALL give diff = 0xFFFF, b_out = 1.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, with busy = 0, done = 0, diff = 0, b_out = 0, ovf = 0, and SHALL clear all internal registers.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-027 With SUB16_OVF_EN defined, SHALL provide ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) on the captured operands, updated with done.
REQ-028 Without SUB16_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default DATA_W/SLICE_W constants.
REQ-030 SHALL instantiate one combinational sub-module sub4 (SLICE_W-bit ripple subtractor: x, y, bin -> d, bout), used once per cycle on the current slice.

Verification
REQ-031 Bench SHALL cover: a = 0x1234, b = 0x0234, b_in = 0, start -> done 5 cycles later with diff = 0x1000, b_out = 0.
REQ-032 Bench SHALL cover: a = 0x0000, b = 0x0001, b_in = 0 -> diff = 0xFFFF, b_out = 1; a = 0x0005, b = 0x0005, b_in = 1 -> diff = 0xFFFF, b_out = 1.
REQ-033 Bench SHALL cover, with SUB16_OVF_EN: a = 0x8000, b = 0x0001 -> diff = 0x7FFF, ovf = 1; a = 0x7FFF, b = 0xFFFF -> diff = 0x8000, ovf = 1; a = 0x0003, b = 0x0001 -> ovf = 0.
REQ-034 Bench SHALL cover: start held during RUN with changing a/b -> ignored; result matches captured operands; exactly one done pulse.
REQ-035 Bench SHALL cover: start asserted in the done cycle with new operands -> accepted; second done exactly 5 cycles after the first.
REQ-036 Bench SHALL cover: rst_n pulsed low at RUN cycle 2 -> busy = 0, diff = 0, no done; a subsequent start of 0xFFFF - 0x0001 -> diff = 0xFFFE.
